// File: rtl/counter_mod.sv
`timescale 1ns/1ps
// Up/down counter with programmable step, wrap or saturate at 0..MAX,
// synchronous clear/load and a registered bound-crossing pulse.
module counter_mod #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0] MAX_X = {1'b0, MAX};
  localparam logic [WIDTH:0] MOD   = MAX_X + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] step_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt_count;
  logic             nxt_ovf;

  // Sum is kept one bit wider so the bound compare sees the true value.
  always_comb begin
    step_eff  = (step > MAX) ? MAX : step;
    sum       = {1'b0, count} + {1'b0, step_eff};
    nxt_count = count;
    nxt_ovf   = 1'b0;
    if (clr) begin
      nxt_count = '0;
    end else if (ld) begin
      nxt_count = (din > MAX) ? MAX : din;
    end else if (en) begin
      if (up) begin
        if (sum > MAX_X) begin
          nxt_ovf   = 1'b1;
          nxt_count = sat ? MAX : WIDTH'(sum - MOD);
        end else begin
          nxt_count = WIDTH'(sum);
        end
      end else begin
        if (step_eff > count) begin
          nxt_ovf   = 1'b1;
          nxt_count = sat ? '0 : WIDTH'({1'b0, count} + MOD - {1'b0, step_eff});
        end else begin
          nxt_count = count - step_eff;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= nxt_count;
      ovf   <= nxt_ovf;
    end
  end

  assign at_max = (count == MAX);
  assign at_min = (count == '0);

endmodule

// File: doc/counter_mod.md
COUNTER_MOD -- requirements
Module: counter_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 8: count width in bits, range 2..32.
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1: terminal value, range 1..2**WIDTH-1; the count range is 0..MAX.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-007 SHALL have port step, input, WIDTH bits: amount added or subtracted per enabled cycle.
REQ-008 SHALL have port sat, input, 1 bit: bound mode, 1 = saturate, 0 = wrap modulo MAX+1.
REQ-009 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-010 SHALL have port ld, input, 1 bit: synchronous load.
REQ-011 SHALL have port din, input, WIDTH bits: load value.
REQ-012 SHALL have port count, output, WIDTH bits: registered count.
REQ-013 SHALL have port ovf, output, 1 bit: registered one-cycle pulse flagging a bound crossing.
REQ-014 SHALL have ports at_max and at_min, output, 1 bit each: combinational flags, count==MAX and count==0.

Function
REQ-015 SHALL apply per-edge priority clr > ld > en; when none is asserted, count SHALL hold.
REQ-016 On clr, count SHALL become 0 and ovf SHALL be 0 on the next cycle.
REQ-017 On ld, count SHALL become din when din<=MAX, else MAX; ovf SHALL be 0.
REQ-018 The effective step SHALL be min(step, MAX); step==0 with en SHALL hold count and keep ovf 0.
REQ-019 Increment SHALL compute count+step_eff at WIDTH+1 bits, with no truncation before the bound compare.
REQ-020 Up, sum<=MAX: count SHALL become sum and ovf SHALL be 0.
REQ-021 Up, sum>MAX, sat=0: count SHALL become sum-(MAX+1) and ovf SHALL be 1.
REQ-022 Up, sum>MAX, sat=1: count SHALL become MAX and ovf SHALL be 1.
REQ-023 Down, step_eff<=count: count SHALL become count-step_eff and ovf SHALL be 0.
REQ-024 Down, step_eff>count, sat=0: count SHALL become count+(MAX+1)-step_eff and ovf SHALL be 1.
REQ-025 Down, step_eff>count, sat=1: count SHALL become 0 and ovf SHALL be 1.
REQ-026 In saturate mode, a further step at a bound in the same direction (e.g. up at MAX, step>0) SHALL hold count and assert ovf every such cycle.
REQ-027 ovf SHALL be high exactly one cycle per crossing event; consecutive crossings SHALL produce ovf high on consecutive cycles.
REQ-028 up, sat and step SHALL be sampled every cycle, so a change takes effect on the next enabled edge with no pipeline delay.
REQ-029 count SHALL never leave 0..MAX under any input sequence.

Reset
REQ-030 While rst=0, count SHALL be 0 and ovf SHALL be 0 immediately, independent of clk; at_min SHALL be 1 and at_max SHALL be 0.
REQ-031 Reset asserted mid-count SHALL discard any pending update; after rst releases, the first rising edge SHALL obey REQ-015.

Verification (WIDTH=8, MAX=9 unless stated)
REQ-032 Reset, then en=1, up=1, step=1, sat=0 for 12 edges -> count 1..9,0,1,2; ovf high only the cycle count shows 0.
REQ-033 count=7, up=1, step=5, sat=0 -> count 2, ovf=1; repeat with sat=1 -> count 9, ovf=1, then 9 held with ovf=1 each further edge.
REQ-034 count=2, up=0, step=4: sat=0 -> count 8, ovf=1; sat=1 -> count 0, at_min=1.
REQ-035 clr=1, ld=1, en=1 with din=5 on the same edge -> count 0; ld=1, en=1, din=200 -> count 9, ovf=0.
REQ-036 Default MAX (255), count=250, step=10, up=1, sat=0 -> count 4, ovf=1 (9-bit sum check).
REQ-037 rst pulsed low between edges while count=6 -> count 0 before the next edge; en=1, step=3 afterwards -> 3.
